// File: rtl/pixel_binner.sv
// RGB565 camera pixel binner: averages BIN x BIN pixel blocks per channel and
// streams the OUT_DIM x OUT_DIM x 3 result into the NPU input memory as planar R, G, B.
module pixel_binner #(
    parameter int OUT_DIM = 32,
    parameter int BIN     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        npu_we,
    output logic [11:0] npu_addr,
    output logic [7:0]  npu_data,
    output logic        frame_done,
    output logic        ovf_err
);

    localparam int LB    = $clog2(BIN);
    localparam int S     = 8 + 2 * LB;
    localparam int WIN   = OUT_DIM * BIN;
    localparam int BXW   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int PLANE = OUT_DIM * OUT_DIM;
    localparam int CW    = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        WR_R,
        WR_G,
        WR_B
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   row_reg;
    logic [CW-1:0]   col_reg;
    logic            row_seen_reg;
    logic [7:0]      cap_g_reg;
    logic [7:0]      cap_b_reg;
    logic [11:0]     base_reg;
    logic            last_reg;

    logic [CW-1:0]   row_inc;
    logic [CW-1:0]   col_inc;
    logic [CW-1:0]   eff_row;
    logic [CW-1:0]   eff_col;
    logic            in_win;
    logic [BXW-1:0]  bx;
    logic [BXW-1:0]  by;
    logic            load;
    logic            active;
    logic            accept;
    logic            acc_we;
    logic            done_bin;
    logic            drop;
    logic            last_next;
    logic [11:0]     base_next;
    logic [7:0]      ch8      [3];
    logic [S-1:0]    sum_next [3];

    // Counters saturate so very wide/tall frames never wrap back into the window.
    assign row_inc = (row_reg == '1) ? row_reg : row_reg + 1'b1;
    assign col_inc = (col_reg == '1) ? col_reg : col_reg + 1'b1;

    // A line start in the same cycle as a pixel takes effect first.
    assign eff_row = line_start ? (row_seen_reg ? row_inc : '0) : row_reg;
    assign eff_col = line_start ? '0 : col_reg;

    assign in_win    = (eff_row < CW'(WIN)) && (eff_col < CW'(WIN));
    assign bx        = eff_col[LB +: BXW];
    assign by        = eff_row[LB +: BXW];
    assign load      = (eff_row[LB-1:0] == '0) && (eff_col[LB-1:0] == '0);
    assign active    = (state_reg != IDLE) && !frame_start;
    assign accept    = (state_reg == ACCUM) && pix_valid && !frame_start;
    assign acc_we    = accept && in_win;
    assign done_bin  = acc_we && (&eff_row[LB-1:0]) && (&eff_col[LB-1:0]);
    assign drop      = active && pix_valid && in_win &&
                       ((state_reg == WR_R) || (state_reg == WR_G) || (state_reg == WR_B));
    assign last_next = (bx == BXW'(OUT_DIM - 1)) && (by == BXW'(OUT_DIM - 1));
    assign base_next = 12'(by) * 12'(OUT_DIM) + 12'(bx);

    assign ch8[0] = {pix_data[15:11], pix_data[15:13]};
    assign ch8[1] = {pix_data[10:5],  pix_data[10:9]};
    assign ch8[2] = {pix_data[4:0],   pix_data[4:2]};

    // The first pixel of each bin overwrites its entry, so stale sums never need clearing.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [S-1:0] acc_mem [OUT_DIM];
            logic [S-1:0] acc_rd;

            assign acc_rd       = acc_mem[bx];
            assign sum_next[gi] = load ? S'(ch8[gi]) : acc_rd + S'(ch8[gi]);

            always_ff @(posedge clk) begin
                if (acc_we) begin
                    acc_mem[bx] <= sum_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            row_reg      <= '0;
            col_reg      <= '0;
            row_seen_reg <= 1'b0;
            cap_g_reg    <= '0;
            cap_b_reg    <= '0;
            base_reg     <= '0;
            last_reg     <= 1'b0;
            npu_we       <= 1'b0;
            npu_addr     <= '0;
            npu_data     <= '0;
            frame_done   <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start) begin
                state_reg    <= ACCUM;
                row_reg      <= '0;
                col_reg      <= '0;
                row_seen_reg <= 1'b0;
                npu_we       <= 1'b0;
                npu_addr     <= '0;
                npu_data     <= '0;
            end else begin
                if (active) begin
                    if (line_start) begin
                        row_seen_reg <= 1'b1;
                        row_reg      <= eff_row;
                        col_reg      <= accept ? CW'(1) : '0;
                    end else if (accept) begin
                        col_reg <= col_inc;
                    end
                    if (drop) begin
                        ovf_err <= 1'b1;
                    end
                end

                case (state_reg)
                    ACCUM: begin
                        if (done_bin) begin
                            npu_we    <= 1'b1;
                            npu_addr  <= base_next;
                            npu_data  <= sum_next[0][S-1 -: 8];
                            cap_g_reg <= sum_next[1][S-1 -: 8];
                            cap_b_reg <= sum_next[2][S-1 -: 8];
                            base_reg  <= base_next;
                            last_reg  <= last_next;
                            state_reg <= WR_R;
                        end
                    end
                    WR_R: begin
                        npu_addr  <= base_reg + 12'(PLANE);
                        npu_data  <= cap_g_reg;
                        state_reg <= WR_G;
                    end
                    WR_G: begin
                        npu_addr  <= base_reg + 12'(2 * PLANE);
                        npu_data  <= cap_b_reg;
                        state_reg <= WR_B;
                    end
                    WR_B: begin
                        npu_we     <= 1'b0;
                        npu_addr   <= '0;
                        npu_data   <= '0;
                        frame_done <= last_reg;
                        state_reg  <= last_reg ? IDLE : ACCUM;
                    end
                    default: begin
                        npu_we    <= 1'b0;
                        npu_addr  <= '0;
                        npu_data  <= '0;
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_binner.sv
// Directed bench for pixel_binner using a reduced 4x4-bin grid (16x16 window) so
// whole frames stay short; expected images come from a plain block-mean model.
module tb_pixel_binner;

    localparam int OD    = 4;
    localparam int BN    = 4;
    localparam int WIN   = OD * BN;
    localparam int PLANE = OD * OD;
    localparam int NWR   = 3 * PLANE;
    localparam int FW    = 20;
    localparam int FH    = 18;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = '0;
    logic        npu_we;
    logic [11:0] npu_addr;
    logic [7:0]  npu_data;
    logic        frame_done;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    int          pcyc = 0;
    int          last_p = 0;
    int          wr_count = 0;
    int          done_count = 0;
    int          oob_count = 0;
    int          zero_viol = 0;
    int          wr_cyc_log [64];
    logic [11:0] wr_addr_log [64];
    logic [7:0]  wr_data_log [64];
    logic [7:0]  mem [4096];

    pixel_binner #(.OUT_DIM(OD), .BIN(BN)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_start(frame_start),
        .line_start (line_start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .npu_we     (npu_we),
        .npu_addr   (npu_addr),
        .npu_data   (npu_data),
        .frame_done (frame_done),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    always @(negedge clk) begin
        if (npu_we) begin
            if (wr_count < 64) begin
                wr_cyc_log[wr_count]  = pcyc;
                wr_addr_log[wr_count] = npu_addr;
                wr_data_log[wr_count] = npu_data;
            end
            if (int'(npu_addr) >= NWR) oob_count++;
            mem[npu_addr] = npu_data;
            wr_count++;
        end else if (npu_addr != 0 || npu_data != 0) begin
            zero_viol++;
        end
        if (frame_done) done_count++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pixval(input int mode, input int r, input int c);
        logic [4:0] c5;
        c5 = 5'(c);
        case (mode)
            0:       return 16'hF800;
            1:       return {c5, 11'b0};
            default: return (r >= WIN || c >= WIN) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    function automatic int expand(input logic [15:0] p, input int ch);
        case (ch)
            0:       return int'({p[15:11], p[15:13]});
            1:       return int'({p[10:5], p[10:9]});
            default: return int'({p[4:0], p[4:2]});
        endcase
    endfunction

    function automatic int exp_bin(input int mode, input int ch, input int by, input int bx);
        int sum = 0;
        for (int r = 0; r < BN; r++)
            for (int c = 0; c < BN; c++)
                sum += expand(pixval(mode, by * BN + r, bx * BN + c), ch);
        return sum / (BN * BN);
    endfunction

    task automatic clear_log();
        wr_count   = 0;
        done_count = 0;
        oob_count  = 0;
        zero_viol  = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 'x;
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic send_pix(input logic [15:0] d, input bit ls);
        @(negedge clk);
        last_p    = pcyc;
        pix_valid = 1'b1;
        line_start = ls;
        pix_data  = d;
        @(negedge clk);
        pix_valid  = 1'b0;
        line_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input int mode, input bit with_fs);
        if (with_fs) pulse_fs();
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < FW; c++)
                send_pix(pixval(mode, r, c), c == 0);
        repeat (20) @(negedge clk);
    endtask

    // Feeds only bin (0,0) of a 0xF800 frame; last_p marks the completing pixel.
    task automatic first_bin_only();
        pulse_fs();
        for (int r = 0; r < BN; r++)
            for (int c = 0; c < BN; c++) begin
                if (r == BN - 1 && c == BN - 1) begin
                    @(negedge clk);
                    last_p    = pcyc;
                    pix_valid = 1'b1;
                    pix_data  = 16'hF800;
                    @(negedge clk);
                    pix_valid = 1'b0;
                end else begin
                    send_pix(16'hF800, c == 0);
                end
            end
    endtask

    task automatic check_image(input int mode, input string tag);
        int mism = 0;
        for (int ch = 0; ch < 3; ch++)
            for (int by = 0; by < OD; by++)
                for (int bx = 0; bx < OD; bx++)
                    if (mem[ch * PLANE + by * OD + bx] !== 8'(exp_bin(mode, ch, by, bx))) mism++;
        chk({tag, "_image_mism"}, mism, 0);
        chk({tag, "_wr_count"}, wr_count, NWR);
        chk({tag, "_done_count"}, done_count, 1);
        chk({tag, "_oob"}, oob_count, 0);
        chk({tag, "_zero_idle"}, zero_viol, 0);
    endtask

    initial begin
        int seen;
        clear_log();
        repeat (3) @(negedge clk);
        chk("rst_we", int'(npu_we), 0);
        chk("rst_addr", int'(npu_addr), 0);
        chk("rst_data", int'(npu_data), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_ovf", int'(ovf_err), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Constant red frame.
        clear_log();
        send_frame(0, 1'b1);
        check_image(0, "red");
        chk("red_r0", int'(mem[0]), 8'hFF);
        chk("red_g0", int'(mem[PLANE]), 8'h00);
        chk("red_b_last", int'(mem[NWR - 1]), 8'h00);
        chk("red_ovf", int'(ovf_err), 0);

        // Red ramp along columns.
        clear_log();
        send_frame(1, 1'b1);
        check_image(1, "ramp");
        chk("ramp_bx0", int'(mem[0]), 8'h0C);
        chk("ramp_bx1", int'(mem[1]), 8'h2D);
        chk("ramp_bx3_row3", int'(mem[15]), 8'h6F);
        chk("ramp_ovf", int'(ovf_err), 0);

        // Bright border outside the window must be ignored.
        clear_log();
        send_frame(2, 1'b1);
        check_image(2, "border");
        chk("border_ovf", int'(ovf_err), 0);

        // Pixel arriving two cycles after a bin completes.
        clear_log();
        first_bin_only();
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = 16'hF800;
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("ovf_set", int'(ovf_err), 1);
        chk("ovf_wr_count", wr_count, 3);
        chk("ovf_r_cyc", wr_cyc_log[0], last_p + 1);
        chk("ovf_g_cyc", wr_cyc_log[1], last_p + 2);
        chk("ovf_b_cyc", wr_cyc_log[2], last_p + 3);
        chk("ovf_r_addr", int'(wr_addr_log[0]), 0);
        chk("ovf_g_addr", int'(wr_addr_log[1]), PLANE);
        chk("ovf_b_addr", int'(wr_addr_log[2]), 2 * PLANE);
        chk("ovf_r_data", int'(wr_data_log[0]), 8'hFF);
        chk("ovf_g_data", int'(wr_data_log[1]), 8'h00);

        // frame_start during WR_G aborts the pending B write.
        clear_log();
        first_bin_only();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_wr_count", wr_count, 2);
        chk("ovf_sticky", int'(ovf_err), 1);
        clear_log();
        send_frame(1, 1'b1);
        check_image(1, "after_abort");

        // Asynchronous reset in the middle of a write burst.
        clear_log();
        first_bin_only();
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (npu_we) seen = 1;
            else @(negedge clk);
        end
        chk("rst_wait_we", seen, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_we", int'(npu_we), 0);
        chk("rst_async_ovf", int'(ovf_err), 0);
        @(negedge clk);
        resetn = 1'b1;
        clear_log();
        send_frame(0, 1'b0);
        chk("nofs_wr_count", wr_count, 0);
        chk("nofs_done", done_count, 0);
        clear_log();
        send_frame(0, 1'b1);
        check_image(0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
